// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths and entry type for the store buffer
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package store_buffer_pkg;
    localparam int SB_ADDR_W = `ADDR_WIDTH;
    localparam int SB_DATA_W = `DATA_WIDTH;
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_youngest_match.sv
// sb_youngest_match: picks the youngest valid matching entry, scanning from head toward tail
module sb_youngest_match #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_valid,
    input  logic [DEPTH-1:0] i_match,
    input  logic [PW-1:0]    i_head,
    output logic             o_hit,
    output logic [PW-1:0]    o_idx
);
    logic [PW-1:0] w_idx;
    // Valid entries are contiguous from head, so the last match seen is the youngest
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if (i_valid[w_idx] && i_match[w_idx]) begin
                o_hit = 1'b1;
                o_idx = w_idx;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO draining to the D-cache with load forwarding and coalescing
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int COALESCE   = 1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_st_valid,
    input  logic [ADDR_WIDTH-1:0] i_st_addr,
    input  logic [DATA_WIDTH-1:0] i_st_data,
    output logic                  o_st_ready,
    input  logic                  i_ld_valid,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    output logic                  o_ld_hit,
    output logic [DATA_WIDTH-1:0] o_ld_data,
    output logic                  o_dc_valid,
    output logic [ADDR_WIDTH-1:0] o_dc_addr,
    output logic [DATA_WIDTH-1:0] o_dc_data,
    input  logic                  i_dc_done,
    output logic                  o_empty,
    output logic [CW-1:0]         o_count
);
    sb_entry_t        r_ent [DEPTH];
    sb_entry_t        w_ent [DEPTH];
    sb_entry_t        r_dc;
    logic [PW-1:0]    r_head, r_tail, w_head, w_tail, w_ld_idx, w_mg_idx;
    logic [CW-1:0]    r_count, w_count;
    logic [DEPTH-1:0] w_valid, w_ld_match, w_mg_match;
    logic             w_ld_hit, w_mg_hit, w_push, w_pop, w_merge;

    always_comb begin
        w_valid    = '0;
        w_ld_match = '0;
        w_mg_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i]    = r_ent[i].valid;
            w_ld_match[i] = r_ent[i].addr == i_ld_addr;
            // The head may already be in flight to the cache, so it is never merged into
            w_mg_match[i] = (COALESCE != 0) && (r_ent[i].addr == i_st_addr) && (PW'(i) != r_head);
        end
    end

    sb_youngest_match #(.DEPTH(DEPTH)) u_ld_match (
        .i_valid (w_valid),
        .i_match (w_ld_match),
        .i_head  (r_head),
        .o_hit   (w_ld_hit),
        .o_idx   (w_ld_idx)
    );

    sb_youngest_match #(.DEPTH(DEPTH)) u_mg_match (
        .i_valid (w_valid),
        .i_match (w_mg_match),
        .i_head  (r_head),
        .o_hit   (w_mg_hit),
        .o_idx   (w_mg_idx)
    );

    assign o_st_ready = (r_count < CW'(DEPTH)) || w_mg_hit;
    assign w_push     = i_st_valid && o_st_ready;
    assign w_merge    = w_push && w_mg_hit;
    assign w_pop      = r_dc.valid && i_dc_done;

    always_comb begin
        w_ent   = r_ent;
        w_head  = r_head;
        w_tail  = r_tail;
        if (w_pop) begin
            w_ent[r_head].valid = 1'b0;
            w_head              = r_head + PW'(1);
        end
        if (w_merge) begin
            w_ent[w_mg_idx].data = i_st_data;
        end else if (w_push) begin
            w_ent[r_tail] = '{valid: 1'b1, addr: i_st_addr, data: i_st_data};
            w_tail        = r_tail + PW'(1);
        end
        w_count = r_count + CW'(w_push && !w_merge) - CW'(w_pop);
    end

    // Drain port is a registered copy of the next head entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_dc    <= '0;
        end else begin
            r_ent   <= w_ent;
            r_head  <= w_head;
            r_tail  <= w_tail;
            r_count <= w_count;
            r_dc    <= w_ent[w_head];
        end
    end

    assign o_dc_valid = r_dc.valid;
    assign o_dc_addr  = r_dc.addr;
    assign o_dc_data  = r_dc.data;
    assign o_ld_hit   = i_ld_valid && w_ld_hit;
    assign o_ld_data  = o_ld_hit ? r_ent[w_ld_idx].data : '0;
    assign o_empty    = r_count == '0;
    assign o_count    = r_count;
endmodule
